ram_arbiter: RTL and testbench

- Arbitrates the single shared RAM port between CPUS cores. Each core presents one instruction-fetch request and one data request.
- Sits between the per-core cache request/response signals and RAM, replacing single-core pass-through steering.
- Data requests always win over instruction requests. Within each class, cores are served round-robin.
- A data grant is held for a full cache block of BLOCK_WORDS word accesses, so block fills and writebacks are never interleaved.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/ram_arbiter_if.sv | 32 +++
 rtl/ram_arbiter_rr_pick.sv | 30 +++
 rtl/ram_arbiter.sv | 126 ++++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM arbitration path.
// Holds the RAM handshake states, arbiter FSM states and request classes.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef enum logic {ARB, XFER} arb_state_t;

    typedef enum logic {INST, DATA} req_class_t;

    // Index width that stays legal for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Per-core cache request/response bundle plus the shared RAM port.
// slave = arbiter view; master = cores and RAM driving the arbiter.
interface ram_arbiter_if import cpu_types_pkg::*; #(
    parameter int CPUS = 2
);
    logic  [CPUS-1:0] iREN;
    logic  [CPUS-1:0] dREN;
    logic  [CPUS-1:0] dWEN;
    logic  [CPUS-1:0] iwait;
    logic  [CPUS-1:0] dwait;
    word_t [CPUS-1:0] iaddr;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;
    logic             ramREN;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    word_t            ramload;
    ramstate_t        ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping.
// Purely combinational; no handshake of its own.
module rr_pick import cpu_types_pkg::*; #(
    parameter  int N  = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);
    logic [IW:0] w_c;

    // Scan from the farthest candidate down so the nearest one to ptr wins.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        w_c   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_c = {1'b0, i_ptr} + (IW + 1)'(k);
            if (w_c >= (IW + 1)'(N)) begin
                w_c = w_c - (IW + 1)'(N);
            end
            if (i_req[w_c[IW-1:0]]) begin
                o_vld = 1'b1;
                o_idx = w_c[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port among CPUS cores: data before fetch, round-robin per class.
// One ARB cycle per grant; cores wait on iwait/dwait until RAM reports ACCESS.
module ram_arbiter import cpu_types_pkg::*; #(
    parameter int CPUS        = 2,
    parameter int BLOCK_WORDS = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    ram_arbiter_if.slave bus
);
    localparam int              PW        = idx_w(CPUS);
    localparam int              CW        = idx_w(BLOCK_WORDS);
    localparam logic [CW-1:0]   LAST_WORD = CW'(BLOCK_WORDS - 1);
    localparam logic [PW-1:0]   LAST_CPU  = PW'(CPUS - 1);

    arb_state_t      r_state, w_state_nx;
    req_class_t      r_class, w_class_nx;
    logic [PW-1:0]   r_owner, w_owner_nx;
    logic [PW-1:0]   r_dptr,  w_dptr_nx;
    logic [PW-1:0]   r_iptr,  w_iptr_nx;
    logic [CW-1:0]   r_cnt,   w_cnt_nx;
    logic [CPUS-1:0] w_dreq;
    logic            w_dvld, w_ivld;
    logic [PW-1:0]   w_didx, w_iidx, w_owner_inc;

    assign w_dreq      = bus.dREN | bus.dWEN;
    assign w_owner_inc = (r_owner == LAST_CPU) ? '0 : r_owner + PW'(1);

    rr_pick #(.N(CPUS)) u_dpick (
        .i_req (w_dreq),
        .i_ptr (r_dptr),
        .o_vld (w_dvld),
        .o_idx (w_didx)
    );

    rr_pick #(.N(CPUS)) u_ipick (
        .i_req (bus.iREN),
        .i_ptr (r_iptr),
        .o_vld (w_ivld),
        .o_idx (w_iidx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ARB;
            r_class <= INST;
            r_owner <= '0;
            r_dptr  <= '0;
            r_iptr  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_class <= w_class_nx;
            r_owner <= w_owner_nx;
            r_dptr  <= w_dptr_nx;
            r_iptr  <= w_iptr_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_class_nx   = r_class;
        w_owner_nx   = r_owner;
        w_dptr_nx    = r_dptr;
        w_iptr_nx    = r_iptr;
        w_cnt_nx     = r_cnt;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        case (r_state)
            ARB: begin
                if (w_dvld) begin
                    w_owner_nx = w_didx;
                    w_class_nx = DATA;
                    w_state_nx = XFER;
                end else if (w_ivld) begin
                    w_owner_nx = w_iidx;
                    w_class_nx = INST;
                    w_state_nx = XFER;
                end
            end
            XFER: begin
                if (r_class == DATA) begin
                    // Live owner signals let the cache walk addresses within the block.
                    bus.ramWEN   = bus.dWEN[r_owner];
                    bus.ramREN   = ~bus.dWEN[r_owner];
                    bus.ramaddr  = bus.daddr[r_owner];
                    bus.ramstore = bus.dstore[r_owner];
                    if (bus.ramstate == ACCESS) begin
                        bus.dwait[r_owner] = 1'b0;
                        bus.dload[r_owner] = bus.ramload;
                        if (r_cnt == LAST_WORD) begin
                            w_cnt_nx   = '0;
                            w_dptr_nx  = w_owner_inc;
                            w_state_nx = ARB;
                        end else begin
                            w_cnt_nx = r_cnt + CW'(1);
                        end
                    end else if (!w_dreq[r_owner]) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ARB;
                    end
                end else begin
                    bus.ramREN  = 1'b1;
                    bus.ramaddr = bus.iaddr[r_owner];
                    if (bus.ramstate == ACCESS) begin
                        bus.iwait[r_owner] = 1'b0;
                        bus.iload[r_owner] = bus.ramload;
                        w_iptr_nx  = w_owner_inc;
                        w_state_nx = ARB;
                    end else if (!bus.iREN[r_owner]) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ARB;
                    end
                end
            end
            default: w_state_nx = ARB;
        endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a grant-level reference model checked every cycle.
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int CPUS = 2;
    localparam int BW   = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    ram_arbiter_if #(.CPUS(CPUS)) bus ();

    ram_arbiter #(.CPUS(CPUS), .BLOCK_WORDS(BW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who holds the port, which class, words done, next-turn pointers.
    bit m_busy = 0, m_data = 0;
    int m_own = 0, m_words = 0, m_dptr = 0, m_iptr = 0;
    bit n_busy = 0, n_data = 0;
    int n_own = 0, n_words = 0, n_dptr = 0, n_iptr = 0;
    int g_log[$];   // grants: 100+core for data, core for fetch
    int p_log[$];   // completed words seen on the DUT waits, same encoding

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_first(input logic [CPUS-1:0] req, input int ptr);
        for (int k = 0; k < CPUS; k++) begin
            if (req[(ptr + k) % CPUS]) return (ptr + k) % CPUS;
        end
        return -1;
    endfunction

    task automatic model_check();
        logic [CPUS-1:0]  e_iw, e_dw, dreq;
        word_t [CPUS-1:0] e_il, e_dl;
        logic             e_ren, e_wen;
        word_t            e_addr, e_st;
        int               lows;
        e_iw = '1; e_dw = '1; e_il = '0; e_dl = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_st = '0;
        n_busy = m_busy; n_data = m_data; n_own = m_own;
        n_words = m_words; n_dptr = m_dptr; n_iptr = m_iptr;
        dreq = bus.dREN | bus.dWEN;
        if (!nRST) begin
            n_busy = 0; n_words = 0; n_dptr = 0; n_iptr = 0;
        end else if (!m_busy) begin
            if (dreq != '0) begin
                n_busy = 1; n_data = 1; n_own = rr_first(dreq, m_dptr);
                g_log.push_back(100 + n_own);
            end else if (bus.iREN != '0) begin
                n_busy = 1; n_data = 0; n_own = rr_first(bus.iREN, m_iptr);
                g_log.push_back(n_own);
            end
        end else if (m_data) begin
            e_wen = bus.dWEN[m_own]; e_ren = !bus.dWEN[m_own];
            e_addr = bus.daddr[m_own]; e_st = bus.dstore[m_own];
            if (bus.ramstate == ACCESS) begin
                e_dw[m_own] = 1'b0; e_dl[m_own] = bus.ramload;
                n_words = m_words + 1;
                if (n_words == BW) begin
                    n_busy = 0; n_words = 0; n_dptr = (m_own + 1) % CPUS;
                end
            end else if (!dreq[m_own]) begin
                n_busy = 0; n_words = 0;
            end
        end else begin
            e_ren = 1'b1; e_addr = bus.iaddr[m_own];
            if (bus.ramstate == ACCESS) begin
                e_iw[m_own] = 1'b0; e_il[m_own] = bus.ramload;
                n_busy = 0; n_iptr = (m_own + 1) % CPUS;
            end else if (!bus.iREN[m_own]) begin
                n_busy = 0; n_words = 0;
            end
        end
        chk("iwait",    128'(bus.iwait),    128'(e_iw));
        chk("dwait",    128'(bus.dwait),    128'(e_dw));
        chk("iload",    128'(bus.iload),    128'(e_il));
        chk("dload",    128'(bus.dload),    128'(e_dl));
        chk("ramREN",   128'(bus.ramREN),   128'(e_ren));
        chk("ramWEN",   128'(bus.ramWEN),   128'(e_wen));
        chk("ramaddr",  128'(bus.ramaddr),  128'(e_addr));
        chk("ramstore", 128'(bus.ramstore), 128'(e_st));
        lows = 0;
        for (int i = 0; i < CPUS; i++) begin
            if (!bus.dwait[i]) begin lows++; p_log.push_back(100 + i); end
            if (!bus.iwait[i]) begin lows++; p_log.push_back(i); end
        end
        chk("single_wait_low", 128'(lows <= 1), 128'(1));
    endtask

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy <= 0; m_data <= 0; m_own <= 0; m_words <= 0; m_dptr <= 0; m_iptr <= 0;
        end else begin
            m_busy <= n_busy; m_data <= n_data; m_own <= n_own;
            m_words <= n_words; m_dptr <= n_dptr; m_iptr <= n_iptr;
        end
    end

    // Every cycle passes through the model check at the falling edge.
    task automatic tick();
        @(negedge CLK);
        model_check();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gs, ps;
        logic [1:0] rr_dw [8];
        rr_dw = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10};
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        #1;
        chk("reset_iwait",  128'(bus.iwait),  128'(2'b11));
        chk("reset_dwait",  128'(bus.dwait),  128'(2'b11));
        chk("reset_ramREN", 128'(bus.ramREN), 128'(0));
        tick(); tick();
        nRST = 1'b1;

        // Reset asserted while a data transfer is stalled on BUSY.
        bus.daddr[0] = 32'h80; bus.dREN = 2'b01; bus.ramstate = BUSY;
        tick();
        chk("pre_rst_ramREN", 128'(bus.ramREN), 128'(1));
        tick();
        nRST = 1'b0;
        #1;
        chk("mid_rst_dwait",   128'(bus.dwait),   128'(2'b11));
        chk("mid_rst_ramREN",  128'(bus.ramREN),  128'(0));
        chk("mid_rst_ramaddr", 128'(bus.ramaddr), 128'(0));
        bus.dREN = '0;
        tick();
        nRST = 1'b1;
        bus.daddr[1] = 32'h84; bus.dREN = 2'b11;
        tick();
        chk("post_rst_dptr0", 128'(bus.ramaddr), 128'(32'h80));
        bus.dREN = '0;
        tick();
        chk("drop_to_arb", 128'(bus.ramREN), 128'(0));

        // Single fetch, ACCESS on the third XFER cycle.
        ps = p_log.size();
        bus.iaddr[0] = 32'h40; bus.iREN = 2'b01;
        tick();
        chk("fetch_addr", 128'(bus.ramaddr), 128'(32'h40));
        chk("fetch_ren",  128'(bus.ramREN),  128'(1));
        tick();
        chk("fetch_wait2", 128'(bus.iwait), 128'(2'b11));
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF; bus.iREN = '0;
        #1;
        chk("fetch_iwait", 128'(bus.iwait),    128'(2'b10));
        chk("fetch_iload", 128'(bus.iload[0]), 128'(32'hDEADBEEF));
        tick();
        bus.ramstate = BUSY;
        chk("fetch_done_iwait", 128'(bus.iwait), 128'(2'b11));
        chk("fetch_pulses", 128'(p_log.size() - ps), 128'(1));

        // Data beats fetch; fetch granted after the second data word.
        gs = g_log.size();
        bus.iaddr[0] = 32'h44; bus.daddr[1] = 32'h90;
        bus.iREN = 2'b01; bus.dREN = 2'b10; bus.ramstate = ACCESS;
        tick();
        chk("prio_w1", 128'(bus.dwait),   128'(2'b01));
        chk("prio_a1", 128'(bus.ramaddr), 128'(32'h90));
        tick();
        chk("prio_w2", 128'(bus.dwait), 128'(2'b01));
        bus.dREN = '0;
        tick();
        chk("prio_arb", 128'({bus.iwait, bus.dwait}), 128'(4'b1111));
        tick();
        chk("prio_fetch", 128'(bus.iwait),   128'(2'b10));
        chk("prio_faddr", 128'(bus.ramaddr), 128'(32'h44));
        bus.iREN = '0;
        tick();
        chk("prio_g0", 128'(g_log[gs]),     128'(101));
        chk("prio_g1", 128'(g_log[gs + 1]), 128'(0));

        // Both cores stream data: block pairs alternate 0,1,0.
        gs = g_log.size(); ps = p_log.size();
        bus.daddr[0] = 32'hA0; bus.daddr[1] = 32'hB0; bus.dREN = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("rr_dwait%0d", c), 128'(bus.dwait), 128'(rr_dw[c]));
            if (c == 7) bus.dREN = '0;
        end
        tick();
        chk("rr_g0", 128'(g_log[gs]),     128'(100));
        chk("rr_g1", 128'(g_log[gs + 1]), 128'(101));
        chk("rr_g2", 128'(g_log[gs + 2]), 128'(100));
        chk("rr_p1", 128'(p_log[ps + 1]), 128'(100));
        chk("rr_p2", 128'(p_log[ps + 2]), 128'(101));
        chk("rr_p5", 128'(p_log[ps + 5]), 128'(100));

        // Write wins over read when both are raised.
        bus.daddr[1] = 32'h100; bus.dstore[1] = 32'h12345678;
        bus.dREN = 2'b10; bus.dWEN = 2'b10; bus.ramstate = BUSY;
        tick();
        chk("wr_wen",   128'(bus.ramWEN),   128'(1));
        chk("wr_ren",   128'(bus.ramREN),   128'(0));
        chk("wr_store", 128'(bus.ramstore), 128'(32'h12345678));
        chk("wr_addr",  128'(bus.ramaddr),  128'(32'h100));
        bus.ramstate = ACCESS;
        #1;
        chk("wr_dwait", 128'(bus.dwait), 128'(2'b01));
        tick();
        bus.dREN = '0; bus.dWEN = '0;
        tick();
        chk("wr_idle", 128'(bus.ramWEN), 128'(0));

        // Abort after one word, then ERROR retried for five cycles.
        bus.daddr[0] = 32'hC0; bus.dREN = 2'b01;
        tick();
        chk("ab_w1", 128'(bus.dwait), 128'(2'b10));
        tick();
        bus.dREN = '0; bus.ramstate = BUSY;
        #1;
        chk("ab_nowait", 128'(bus.dwait), 128'(2'b11));
        tick();
        chk("ab_arb", 128'(bus.ramREN), 128'(0));
        bus.daddr[0] = 32'h200; bus.daddr[1] = 32'h300;
        bus.dREN = 2'b11; bus.ramstate = ERROR;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("err_addr%0d", c),  128'(bus.ramaddr), 128'(32'h200));
            chk($sformatf("err_dwait%0d", c), 128'(bus.dwait),   128'(2'b11));
            tick();
        end
        bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
        #1;
        chk("err_done",  128'(bus.dwait),    128'(2'b10));
        chk("err_dload", 128'(bus.dload[0]), 128'(32'hCAFEF00D));
        chk("err_dload1", 128'(bus.dload[1]), 128'(0));
        tick();
        bus.dREN = 2'b10;
        chk("err_w2", 128'(bus.dwait), 128'(2'b10));
        tick();
        bus.ramstate = BUSY;
        tick();
        chk("err_next_owner", 128'(bus.ramaddr), 128'(32'h300));
        bus.dREN = '0;
        tick();
        chk("end_idle", 128'(bus.ramREN), 128'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
